registro_entrada: RTL and testbench
===================================

Name: registro_entrada

Overview:
- Operand/command capture FSM for the calculator; the producing side of the display-selection path.
- Samples user switches on debounced button presses and registers operand A, operand B and the operation code.
- Drives the 2-bit STATE code (0 none, 1 A, 2 B, 3 result) consumed by the display register and the ALU.
- Pulses CALC when the operation is committed so the ALU/result register latches.

Parameters:
in_length, 16, width of operands and data switches
op_length, 2, width of operation code

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-low reset
DATO_IN  input  in_length  switch value for operands
OP_IN  input  op_length  switch value for operation
BTN_ENTER  input  1  debounced, asynchronous-domain level; rising edge = advance
BTN_UNDO  input  1  debounced, asynchronous-domain level; rising edge = step back
STATE  output  2  0 none entered, 1 A entered, 2 B entered, 3 result valid
A_OUT  output  in_length  registered operand A
B_OUT  output  in_length  registered operand B
OPERACION  output  op_length  registered operation code
CALC  output  1  one-cycle pulse on the 2->3 transition

Behaviour:
- Clock and reset: one clock, CLK; RESET asynchronous, active-low.
- Reset values: STATE=0, A_OUT=0, B_OUT=0, OPERACION=0, CALC=0, all synchronizer/edge flops=0.
- Input conditioning: each button passes through a 2-flop synchronizer plus a delay flop. edge = sync2 & ~dly.
- Edge latency: an action executes on the 3rd rising CLK edge at which the button is sampled high. Outputs are visible after that edge.
- Each press is one event; holding the button causes no repeat.
- ENTER transitions:
  - 0->1: A_OUT <= DATO_IN.
  - 1->2: B_OUT <= DATO_IN.
  - 2->3: OPERACION <= OP_IN, and CALC=1 for exactly that one following cycle.
  - 3->0: A_OUT, B_OUT and OPERACION cleared to 0.
- UNDO transitions:
  - 1->0: clear A_OUT.
  - 2->1: clear B_OUT.
  - 3->2: clear OPERACION; no CALC pulse.
  - UNDO in state 0: ignored.
- ENTER and UNDO edges in the same cycle: both ignored, no state or data change.
- DATO_IN and OP_IN are sampled directly (unsynchronized) on the action edge. Switches are quasi-static, so this is legal.
- Data registers change only on their own transition. DATO_IN changes in other states have no effect.
- CALC is registered. It is 0 in every cycle except the one following the 2->3 action.
- RESET asserted mid-sequence, including the CALC cycle: all outputs return to reset values immediately.
- Presses whose edge flops were partially filled at reset are lost.
- STATE encoding is fixed as 2'd0..2'd3. The display path depends on it.

Decomposition:
- Package calc_pkg:
  - typedef enum logic [1:0] estado_t {E_VACIO=0, E_OP_A=1, E_OP_B=2, E_RESULT=3}.
  - Operation code constants (op_length wide), shared with the ALU.
- Sub-module detector_flanco: 2-flop synchronizer, delay flop and rising-edge pulse output, with async active-low reset.
  - Instantiated twice, once for ENTER and once for UNDO.
- FSM and data registers live in registro_entrada.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, then release -> STATE=0, A_OUT=B_OUT=0, OPERACION=0, CALC=0.
- Full sequence:
  - DATO_IN=16'h0012, press ENTER -> STATE=1, A_OUT=0012 on the 3rd edge.
  - DATO_IN=16'h0034, press ENTER -> STATE=2, B_OUT=0034.
  - OP_IN=2'b01, press ENTER -> STATE=3, OPERACION=01, CALC high exactly one cycle.
  - Press ENTER -> STATE=0, all data 0.
- Held button: ENTER held high 50 cycles from STATE=0 -> exactly one transition (STATE=1). A_OUT unchanged when DATO_IN later changes.
- Undo: in STATE=2 with B_OUT=0034, press UNDO -> STATE=1, B_OUT=0, A_OUT kept. UNDO in STATE=0 -> no change.
- Simultaneous: ENTER and UNDO rise on the same clock in STATE=1 -> STATE stays 1, A_OUT unchanged, CALC=0.
- Reset mid-operation: assert RESET during the CALC cycle of a 2->3 transition -> CALC=0 and STATE=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: capture-FSM state encoding and ALU operation codes.
// The state encoding is fixed because the display register decodes it directly.
package calc_pkg;

  typedef enum logic [1:0] {
    E_VACIO  = 2'd0,
    E_OP_A   = 2'd1,
    E_OP_B   = 2'd2,
    E_RESULT = 2'd3
  } estado_t;

  localparam int OP_LENGTH = 2;

  localparam logic [OP_LENGTH-1:0] OP_SUMA  = 2'b00;
  localparam logic [OP_LENGTH-1:0] OP_RESTA = 2'b01;
  localparam logic [OP_LENGTH-1:0] OP_AND   = 2'b10;
  localparam logic [OP_LENGTH-1:0] OP_OR    = 2'b11;

endpackage

// File: rtl/detector_flanco.sv
// Button conditioner: 2-flop synchronizer plus delay flop; one-cycle pulse per rising edge.
// The pulse is valid in the cycle after the 2nd sampling edge, so the consumer acts on the 3rd.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign pulse = sync2 & ~dly;

endmodule

// File: rtl/registro_entrada.sv
// Operand/command capture FSM: ENTER advances A -> B -> op -> clear, UNDO steps back.
// Actions land on the 3rd edge a button is seen high; CALC pulses one cycle on commit.
module registro_entrada
  import calc_pkg::*;
#(
  parameter int in_length = 16,
  parameter int op_length = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [in_length-1:0] DATO_IN,
  input  logic [op_length-1:0] OP_IN,
  input  logic                 BTN_ENTER,
  input  logic                 BTN_UNDO,
  output logic [1:0]           STATE,
  output logic [in_length-1:0] A_OUT,
  output logic [in_length-1:0] B_OUT,
  output logic [op_length-1:0] OPERACION,
  output logic                 CALC
);

  estado_t estado;
  estado_t estado_sig;
  logic    enter;
  logic    undo;
  logic    avanza;
  logic    retrocede;

  detector_flanco u_enter (
    .clk   (CLK),
    .rst_n (RESET),
    .btn   (BTN_ENTER),
    .pulse (enter)
  );

  detector_flanco u_undo (
    .clk   (CLK),
    .rst_n (RESET),
    .btn   (BTN_UNDO),
    .pulse (undo)
  );

  // Coincident ENTER and UNDO edges cancel each other.
  assign avanza    = enter & ~undo;
  assign retrocede = undo & ~enter;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) estado <= E_VACIO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    if (avanza) begin
      case (estado)
        E_VACIO:  estado_sig = E_OP_A;
        E_OP_A:   estado_sig = E_OP_B;
        E_OP_B:   estado_sig = E_RESULT;
        E_RESULT: estado_sig = E_VACIO;
        default:  estado_sig = E_VACIO;
      endcase
    end else if (retrocede) begin
      case (estado)
        E_OP_A:   estado_sig = E_VACIO;
        E_OP_B:   estado_sig = E_OP_A;
        E_RESULT: estado_sig = E_OP_B;
        default:  estado_sig = estado;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      A_OUT     <= '0;
      B_OUT     <= '0;
      OPERACION <= '0;
      CALC      <= 1'b0;
    end else begin
      CALC <= avanza && (estado == E_OP_B);
      if (avanza) begin
        case (estado)
          E_VACIO:  A_OUT     <= DATO_IN;
          E_OP_A:   B_OUT     <= DATO_IN;
          E_OP_B:   OPERACION <= OP_IN;
          E_RESULT: begin
            A_OUT     <= '0;
            B_OUT     <= '0;
            OPERACION <= '0;
          end
          default: ;
        endcase
      end else if (retrocede) begin
        case (estado)
          E_OP_A:   A_OUT     <= '0;
          E_OP_B:   B_OUT     <= '0;
          E_RESULT: OPERACION <= '0;
          default: ;
        endcase
      end
    end
  end

  assign STATE = estado;

endmodule

// File: tb/tb_registro_entrada.sv
// Directed bench for registro_entrada: reset, full ENTER cycle, held button, undo,
// simultaneous presses and asynchronous reset during the CALC cycle.
module tb_registro_entrada;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] DATO_IN = '0;
  logic [1:0]  OP_IN = '0;
  logic        BTN_ENTER = 1'b0;
  logic        BTN_UNDO = 1'b0;
  logic [1:0]  STATE;
  logic [15:0] A_OUT;
  logic [15:0] B_OUT;
  logic [1:0]  OPERACION;
  logic        CALC;

  int errors = 0;
  int checks = 0;

  registro_entrada #(.in_length(16), .op_length(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATO_IN   (DATO_IN),
    .OP_IN     (OP_IN),
    .BTN_ENTER (BTN_ENTER),
    .BTN_UNDO  (BTN_UNDO),
    .STATE     (STATE),
    .A_OUT     (A_OUT),
    .B_OUT     (B_OUT),
    .OPERACION (OPERACION),
    .CALC      (CALC)
  );

  always #5 CLK = ~CLK;

  // Raise the selected buttons, then stop 1 time unit after the 3rd rising edge.
  task automatic press(input logic ent, input logic und);
    @(negedge CLK);
    BTN_ENTER = ent;
    BTN_UNDO  = und;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic release_btns();
    @(negedge CLK);
    BTN_ENTER = 1'b0;
    BTN_UNDO  = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", STATE); end
    checks++; if (A_OUT !== 16'h0) begin errors++; $display("FAIL reset_a got=%h exp=0000", A_OUT); end
    checks++; if (B_OUT !== 16'h0) begin errors++; $display("FAIL reset_b got=%h exp=0000", B_OUT); end
    checks++; if (OPERACION !== 2'd0) begin errors++; $display("FAIL reset_op got=%b exp=00", OPERACION); end
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL reset_calc got=%b exp=0", CALC); end
  endtask

  task automatic test_full_sequence();
    DATO_IN = 16'h0012;
    @(negedge CLK);
    BTN_ENTER = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL early_state got=%0d exp=0", STATE); end
    @(posedge CLK);
    #1;
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL seq_a_state got=%0d exp=1", STATE); end
    checks++; if (A_OUT !== 16'h0012) begin errors++; $display("FAIL seq_a_val got=%h exp=0012", A_OUT); end
    release_btns();

    DATO_IN = 16'h0034;
    press(1'b1, 1'b0);
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL seq_b_state got=%0d exp=2", STATE); end
    checks++; if (B_OUT !== 16'h0034) begin errors++; $display("FAIL seq_b_val got=%h exp=0034", B_OUT); end
    checks++; if (A_OUT !== 16'h0012) begin errors++; $display("FAIL seq_b_keep_a got=%h exp=0012", A_OUT); end
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL seq_b_calc got=%b exp=0", CALC); end
    release_btns();

    OP_IN = 2'b01;
    press(1'b1, 1'b0);
    checks++; if (STATE !== 2'd3) begin errors++; $display("FAIL seq_op_state got=%0d exp=3", STATE); end
    checks++; if (OPERACION !== 2'b01) begin errors++; $display("FAIL seq_op_val got=%b exp=01", OPERACION); end
    checks++; if (CALC !== 1'b1) begin errors++; $display("FAIL seq_calc_hi got=%b exp=1", CALC); end
    @(posedge CLK);
    #1;
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL seq_calc_lo got=%b exp=0", CALC); end
    release_btns();
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL seq_calc_stays_lo got=%b exp=0", CALC); end

    press(1'b1, 1'b0);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL seq_clr_state got=%0d exp=0", STATE); end
    checks++; if (A_OUT !== 16'h0) begin errors++; $display("FAIL seq_clr_a got=%h exp=0000", A_OUT); end
    checks++; if (B_OUT !== 16'h0) begin errors++; $display("FAIL seq_clr_b got=%h exp=0000", B_OUT); end
    checks++; if (OPERACION !== 2'd0) begin errors++; $display("FAIL seq_clr_op got=%b exp=00", OPERACION); end
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL seq_clr_calc got=%b exp=0", CALC); end
    release_btns();
  endtask

  task automatic test_held();
    DATO_IN = 16'h00AB;
    @(negedge CLK);
    BTN_ENTER = 1'b1;
    repeat (50) @(posedge CLK);
    #1;
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL held_state got=%0d exp=1", STATE); end
    checks++; if (A_OUT !== 16'h00AB) begin errors++; $display("FAIL held_a got=%h exp=00ab", A_OUT); end
    DATO_IN = 16'h1234;
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (A_OUT !== 16'h00AB) begin errors++; $display("FAIL held_a_stable got=%h exp=00ab", A_OUT); end
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL held_state_stable got=%0d exp=1", STATE); end
    release_btns();
  endtask

  task automatic test_undo();
    DATO_IN = 16'h0034;
    press(1'b1, 1'b0);
    release_btns();
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL undo_setup got=%0d exp=2", STATE); end
    DATO_IN = 16'h9999;
    press(1'b0, 1'b1);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL undo_b_state got=%0d exp=1", STATE); end
    checks++; if (B_OUT !== 16'h0) begin errors++; $display("FAIL undo_b_val got=%h exp=0000", B_OUT); end
    checks++; if (A_OUT !== 16'h00AB) begin errors++; $display("FAIL undo_keep_a got=%h exp=00ab", A_OUT); end
    release_btns();
    press(1'b0, 1'b1);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL undo_a_state got=%0d exp=0", STATE); end
    checks++; if (A_OUT !== 16'h0) begin errors++; $display("FAIL undo_a_val got=%h exp=0000", A_OUT); end
    release_btns();
    press(1'b0, 1'b1);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL undo_idle_state got=%0d exp=0", STATE); end
    checks++; if (A_OUT !== 16'h0) begin errors++; $display("FAIL undo_idle_a got=%h exp=0000", A_OUT); end
    release_btns();
  endtask

  task automatic test_simultaneous();
    DATO_IN = 16'h0055;
    press(1'b1, 1'b0);
    release_btns();
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL simul_setup got=%0d exp=1", STATE); end
    DATO_IN = 16'h0066;
    press(1'b1, 1'b1);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL simul_state got=%0d exp=1", STATE); end
    checks++; if (A_OUT !== 16'h0055) begin errors++; $display("FAIL simul_a got=%h exp=0055", A_OUT); end
    checks++; if (B_OUT !== 16'h0) begin errors++; $display("FAIL simul_b got=%h exp=0000", B_OUT); end
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL simul_calc got=%b exp=0", CALC); end
    release_btns();
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL simul_after got=%0d exp=1", STATE); end
  endtask

  task automatic test_reset_mid();
    DATO_IN = 16'h0088;
    press(1'b1, 1'b0);
    release_btns();
    OP_IN = 2'b10;
    press(1'b1, 1'b0);
    checks++; if (CALC !== 1'b1) begin errors++; $display("FAIL mid_calc_hi got=%b exp=1", CALC); end
    #1;
    RESET = 1'b0;
    #1;
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL mid_calc_async got=%b exp=0", CALC); end
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL mid_state_async got=%0d exp=0", STATE); end
    checks++; if (A_OUT !== 16'h0) begin errors++; $display("FAIL mid_a_async got=%h exp=0000", A_OUT); end
    checks++; if (OPERACION !== 2'd0) begin errors++; $display("FAIL mid_op_async got=%b exp=00", OPERACION); end
    @(negedge CLK);
    BTN_ENTER = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL mid_after_state got=%0d exp=0", STATE); end
    checks++; if (CALC !== 1'b0) begin errors++; $display("FAIL mid_after_calc got=%b exp=0", CALC); end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_held();
    test_undo();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
